// File: rtl/fifo_pkg.sv
// Shared FIFO sizing: number of RAM entries and the matching RAM address type.
package fifo_pkg;
   localparam int VECTOR_SIZE = 8;
   typedef logic [$clog2(VECTOR_SIZE)-1:0] address_t;
endpackage

// File: rtl/fifo_ctrl_if.sv
// Request/RAM-control/status bundle between the processor side and fifo_ctrl.
// Optional overflow/underflow flags exist only when FIFO_ERR_FLAGS_EN is defined.
interface fifo_ctrl_if #(
   parameter int AW = 3
);
   logic          push;
   logic          pop;
   logic          wr_en;
   logic          rd_en;
   logic [AW-1:0] count_push;
   logic [AW-1:0] count_pop;
   logic          full;
   logic          empty;
   logic [AW:0]   used;
   logic          data_valid;
   logic [1:0]    fsm_state;
`ifdef FIFO_ERR_FLAGS_EN
   logic          overflow;
   logic          underflow;
`endif

   // Handshake: push/pop are requests, wr_en/rd_en are the same-cycle accepts;
   // a request is taken exactly in a cycle where its enable is high.
`ifdef FIFO_ERR_FLAGS_EN
   modport master (
      output push, pop,
      input  wr_en, rd_en, count_push, count_pop, full, empty, used,
             data_valid, fsm_state, overflow, underflow
   );
   modport slave (
      input  push, pop,
      output wr_en, rd_en, count_push, count_pop, full, empty, used,
             data_valid, fsm_state, overflow, underflow
   );
`else
   modport master (
      output push, pop,
      input  wr_en, rd_en, count_push, count_pop, full, empty, used,
             data_valid, fsm_state
   );
   modport slave (
      input  push, pop,
      output wr_en, rd_en, count_push, count_pop, full, empty, used,
             data_valid, fsm_state
   );
`endif
endinterface

// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller driving a registered-read RAM; EMPTY/NORMAL/FULL FSM.
// Optional sticky overflow/underflow flags enabled by defining FIFO_ERR_FLAGS_EN.
module fifo_ctrl #(
   parameter int DEPTH = fifo_pkg::VECTOR_SIZE,
   parameter int AW    = $clog2(DEPTH)
) (
   input logic        clk,
   input logic        rst,
   fifo_ctrl_if.slave bus
);

   localparam logic [1:0] S_EMPTY  = 2'd0;
   localparam logic [1:0] S_NORMAL = 2'd1;
   localparam logic [1:0] S_FULL   = 2'd2;

   localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
   localparam logic [AW:0]   USED_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   USED_NEAR = (AW+1)'(DEPTH - 1);

   logic [1:0]    state;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   used_q;
   logic          dv_q;
   logic          is_empty;
   logic          is_full;
   logic          wr_acc;
   logic          rd_acc;

   assign is_empty = (state == S_EMPTY);
   assign is_full  = (state == S_FULL);

   // Gating with rst keeps the RAM enables low for every reset cycle,
   // including the first one before the state register has been cleared.
   assign wr_acc = ~rst & bus.push & (~is_full | bus.pop);
   assign rd_acc = ~rst & bus.pop & ~is_empty;

   assign bus.wr_en      = wr_acc;
   assign bus.rd_en      = rd_acc;
   assign bus.count_push = wr_ptr;
   assign bus.count_pop  = rd_ptr;
   assign bus.full       = is_full;
   assign bus.empty      = is_empty;
   assign bus.used       = used_q;
   assign bus.data_valid = dv_q;
   assign bus.fsm_state  = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_EMPTY;
         wr_ptr <= '0;
         rd_ptr <= '0;
         used_q <= '0;
         dv_q   <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
         if (rd_acc) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);

         if (wr_acc & ~rd_acc)      used_q <= used_q + (AW+1)'(1);
         else if (rd_acc & ~wr_acc) used_q <= used_q - (AW+1)'(1);

         // RAM read data is registered, so the strobe lags the accept by one edge.
         dv_q <= rd_acc;

         case (state)
            S_EMPTY:  if (wr_acc) state <= S_NORMAL;
            S_NORMAL: begin
               if ((used_q == USED_ONE) & rd_acc & ~wr_acc)       state <= S_EMPTY;
               else if ((used_q == USED_NEAR) & wr_acc & ~rd_acc) state <= S_FULL;
            end
            S_FULL:   if (rd_acc & ~wr_acc) state <= S_NORMAL;
            default:  state <= S_EMPTY;
         endcase
      end
   end

`ifdef FIFO_ERR_FLAGS_EN
   logic ovf_q;
   logic unf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (bus.push & is_full & ~bus.pop) ovf_q <= 1'b1;
         if (bus.pop & is_empty)            unf_q <= 1'b1;
      end
   end

   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl (DEPTH=8): directed boundary steps then random traffic,
// checked against a queue-based FIFO model with a small registered-read RAM.
module tb_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_ctrl_if #(.AW(AW)) bus ();

  fifo_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Storage array seen by the controller: write at count_push, registered read at count_pop.
  logic [7:0] wdata;
  logic [7:0] mem [DEPTH];
  logic [7:0] data_out;

  always @(posedge clk) begin
    if (bus.wr_en) mem[bus.count_push] <= wdata;
    if (bus.rd_en) data_out <= mem[bus.count_pop];
  end

  // Reference model
  logic [7:0] exp_q[$];
  int         wr_cnt;
  int         rd_cnt;
  logic       exp_dv;
  logic [7:0] exp_dout;
  logic       exp_ovf;
  logic       exp_unf;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic p, input logic q, input logic r, input logic [7:0] d);
    logic wa;
    logic ra;
    int   sz;
    bus.push = p;
    bus.pop  = q;
    rst      = r;
    wdata    = d;
    #1;
    sz = exp_q.size();
    wa = !r && p && (sz < DEPTH || q);
    ra = !r && q && (sz > 0);

    chk("used",       32'(bus.used),       32'(sz));
    chk("full",       32'(bus.full),       32'(sz == DEPTH));
    chk("empty",      32'(bus.empty),      32'(sz == 0));
    chk("count_push", 32'(bus.count_push), 32'(wr_cnt % DEPTH));
    chk("count_pop",  32'(bus.count_pop),  32'(rd_cnt % DEPTH));
    chk("data_valid", 32'(bus.data_valid), 32'(exp_dv));
    if (exp_dv) chk("data_out", 32'(data_out), 32'(exp_dout));
    chk("wr_en",      32'(bus.wr_en),      32'(wa));
    chk("rd_en",      32'(bus.rd_en),      32'(ra));
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow",   32'(bus.overflow),   32'(exp_ovf));
    chk("underflow",  32'(bus.underflow),  32'(exp_unf));
`endif

    @(posedge clk);
    if (r) begin
      exp_q.delete();
      wr_cnt  = 0;
      rd_cnt  = 0;
      exp_dv  = 1'b0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      if (p && sz == DEPTH && !q) exp_ovf = 1'b1;
      if (q && sz == 0)           exp_unf = 1'b1;
      if (ra) begin
        exp_dout = exp_q.pop_front();
        rd_cnt++;
      end
      if (wa) begin
        exp_q.push_back(d);
        wr_cnt++;
      end
      exp_dv = ra;
    end
    #1;
  endtask

  initial begin
    logic [7:0] v;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    rst      = 1'b1;
    wdata    = '0;
    wr_cnt   = 0;
    rd_cnt   = 0;
    exp_dv   = 1'b0;
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with both requests asserted
    cycle(1, 1, 1, 8'hAA);
    cycle(1, 1, 1, 8'hAA);

    // Fill 0x11..0x88, then a rejected 9th push
    for (int i = 1; i <= DEPTH; i++) begin
      v = 8'(i * 8'h11);
      cycle(1, 0, 0, v);
    end
    cycle(1, 0, 0, 8'h99);
    cycle(0, 0, 0, 8'h00);

    // Drain back-to-back, then a rejected 9th pop
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 8'h00);
    cycle(0, 1, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);

    // Push+pop while empty: only the write happens
    cycle(1, 1, 0, 8'h5A);
    cycle(0, 0, 0, 8'h00);

    // Top up to full, then push+pop while full
    for (int i = 0; i < DEPTH - 1; i++) cycle(1, 0, 0, 8'(8'hA0 + i));
    cycle(1, 1, 0, 8'hEE);
    cycle(1, 1, 0, 8'hEF);
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 1, 0, 8'h00);

    // Wrap-around: push 5, pop 5, push 6, pop 6
    cycle(0, 0, 1, 8'h00);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 8'(8'h30 + i));
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 8'h00);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 8'(8'h40 + i));
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);

    // Reset one cycle after a pop from a 3-entry FIFO
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 8'(8'h70 + i));
    cycle(0, 1, 0, 8'h00);
    cycle(0, 0, 1, 8'h00);
    cycle(0, 0, 0, 8'h00);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 99) < 55),
            1'($urandom_range(0, 99) < 50),
            1'($urandom_range(0, 99) == 0),
            8'($urandom));
    end
    cycle(0, 0, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and flag controller for the FIFO. It sits directly upstream of the `ram_vector` storage array and turns the processor-side `push`/`pop` requests into the RAM's `wr_en`, `rd_en`, `count_push` and `count_pop` signals. It also tracks occupancy through a three-state FSM and produces `full`, `empty`, `used` and a `data_valid` strobe that is aligned to the RAM's registered read data.

## Interface
Parameters:
- `DEPTH`, default `VECTOR_SIZE` (from `fifo_pkg`): number of RAM entries; must be ≥2.
- `AW`, default `$clog2(DEPTH)`: pointer width; must match `address_t`.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset. Sampled on `posedge clk`.
- `push` in 1: write request. Data is presented to the RAM's `data_in` in the same cycle.
- `pop` in 1: read request.
- `wr_en` out 1: RAM write enable.
- `rd_en` out 1: RAM read enable.
- `count_push` out AW (`address_t`): RAM write address.
- `count_pop` out AW (`address_t`): RAM read address.
- `full` out 1: FIFO holds DEPTH entries.
- `empty` out 1: FIFO holds 0 entries.
- `used` out AW+1: current occupancy, 0..DEPTH.
- `data_valid` out 1: RAM `data_out` holds a popped word this cycle.
- `overflow` out 1: sticky error flag. Present only with `FIFO_ERR_FLAGS_EN`.
- `underflow` out 1: sticky error flag. Present only with `FIFO_ERR_FLAGS_EN`.

## Operation
- **FSM states:** `EMPTY`, `NORMAL`, `FULL`. The state is registered. `empty = (state==EMPTY)` and `full = (state==FULL)`, both decoded from the state register.
- **Accept rules:**
  - `wr_acc = push & (~full | pop)`.
  - `rd_acc = pop & ~empty`.
  - `wr_en = wr_acc` and `rd_en = rd_acc`. Both are combinational and drive the RAM in the same cycle.
- **Pointers:**
  - `count_push` advances by 1 on `wr_acc`.
  - `count_pop` advances by 1 on `rd_acc`.
  - Each pointer wraps from DEPTH-1 to 0 by explicit compare. Non-power-of-2 DEPTH is legal.
  - The RAM always uses the pre-increment pointer value.
- **Occupancy:** `used` is +1 on `wr_acc` only, −1 on `rd_acc` only, and unchanged when both or neither are accepted. It never leaves 0..DEPTH.
- **FSM transitions (next-occupancy based):**
  - `EMPTY` → `NORMAL` on `wr_acc`. A pop while in `EMPTY` is ignored.
  - `NORMAL` → `EMPTY` when `used==1 & rd_acc & ~wr_acc`.
  - `NORMAL` → `FULL` when `used==DEPTH-1 & wr_acc & ~rd_acc`.
  - `FULL` → `NORMAL` on `rd_acc & ~wr_acc`.
  - All other cases hold the current state.
- **Simultaneous push+pop:**
  - When `EMPTY`: only the write is accepted. There is no fall-through.
  - When `NORMAL` or `FULL`: both are accepted, and occupancy and state are unchanged.
  - When `FULL` with both asserted, `count_push==count_pop`. The RAM returns the old word and writes the new word.
- **Rejected requests:**
  - A push while `FULL` without a pop is dropped. No pointer moves.
  - A pop while `EMPTY` is dropped.
- **Reset:**
  - Pointers = 0, `used` = 0, state = `EMPTY`, `data_valid` = 0, `overflow` = `underflow` = 0.
  - Combinational outputs therefore read `empty`=1, `full`=0, `wr_en`=`rd_en`=0 during reset.
  - A reset asserted mid-operation discards all contents. A `data_valid` pending from the previous cycle is cleared.
  - RAM contents are not cleared.

## Timing
- Write: the data is committed at the edge where `wr_en`=1. It is poppable from the next cycle.
- Read: `rd_en` is asserted in cycle N, and `data_out` is valid in cycle N+1 with `data_valid`=1. `data_valid` is `rd_acc` registered.
- Flags update one edge after the accepting cycle.
- Back-to-back pops sustain one word per cycle.
- `push`/`pop` to `wr_en`/`rd_en` is combinational. There is no request-side latency.

## Configuration
- Macro: `FIFO_ERR_FLAGS_EN`.
- **Defined:**
  - `overflow` sets on the cycle after `push & full & ~pop`.
  - `underflow` sets on the cycle after `pop & empty`.
  - Both stay set until `rst`.
- **Undefined:** the `overflow` and `underflow` ports and their logic are absent. Dropped requests are silent. All other behaviour is identical.

## Test plan
(DEPTH=8)
- **Reset:** hold `rst` 2 cycles with `push`=`pop`=1 → `empty`=1, `full`=0, `used`=0, `wr_en`=`rd_en`=0, both pointers 0.
- **Fill then overflow:**
  - Push 0x11..0x88 on 8 consecutive cycles → `full`=1 after the 8th edge, `used`=8, `count_push`=0.
  - A 9th push → `wr_en`=0, `used` stays 8, `overflow`=1 next cycle (with macro).
- **Drain:**
  - Pop 8× back-to-back from full → `data_out` = 0x11..0x88 on cycles N+1..N+8 with `data_valid`=1.
  - `empty`=1 after the 8th edge. A 9th pop → `rd_en`=0, `underflow`=1.
- **Simultaneous at boundaries:**
  - Push+pop when empty → only the write occurs, `used`=1, `data_valid`=0.
  - Push+pop when full → `used` stays 8, the popped word is the oldest, the new word lands at the old `count_pop` slot.
- **Wrap-around:** push 5, pop 5, push 6 → `count_push` goes 5→7→0→3. Popping 6 returns data in push order across the wrap.
- **Mid-op reset:** `rst` one cycle after a pop of a 3-entry FIFO → `data_valid`=0 the next cycle, `empty`=1, `used`=0.
